// File: rtl/qeciphy_rx_faw_monitor.sv
// FAW framing monitor: hunt/presync/sync on the aligned 64-bit RX stream, FAW stripping, lock reporting.
// Optional build macro QECIPHY_RX_FAW_MON_STATS_EN enables the missing-FAW error counter.
package qeciphy_pkg;
  localparam logic [63:0] FAW_WORD = 64'hA5C3_96F0_0F69_3C5A;

  function automatic logic is_faw(input logic [63:0] word);
    return word == FAW_WORD;
  endfunction
endpackage

module qeciphy_rx_faw_monitor #(
  parameter int FAW_PERIOD   = 64,
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] tdata_64b_i,
  input  logic        aligned_i,
  output logic [63:0] tdata_o,
  output logic        tvalid_o,
  output logic        locked_o,
  output logic        lock_lost_o,
  output logic [15:0] faw_err_cnt_o
);
  localparam int POS_W = $clog2(FAW_PERIOD);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(FAW_PERIOD - 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PRESYNC = 2'd1,
    SYNC    = 2'd2
  } state_t;

  state_t           state_reg;
  logic [63:0]      data_s1_reg;
  logic [POS_W-1:0] pos_reg;
  logic [POS_W-1:0] pos_inc;
  logic [3:0]       good_cnt_reg;
  logic [3:0]       miss_cnt_reg;
  logic             faw_s1;
  logic             slot_s1;
  logic             miss_s1;
  logic             unlock_s1;

  assign faw_s1    = qeciphy_pkg::is_faw(data_s1_reg);
  assign slot_s1   = (pos_reg == '0);
  assign pos_inc   = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
  assign miss_s1   = (state_reg == SYNC) && slot_s1 && !faw_s1;
  assign unlock_s1 = miss_s1 && ((miss_cnt_reg + 4'd1) == UNLOCK_N);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= HUNT;
      data_s1_reg  <= '0;
      pos_reg      <= '0;
      good_cnt_reg <= '0;
      miss_cnt_reg <= '0;
      tdata_o      <= '0;
      tvalid_o     <= 1'b0;
      locked_o     <= 1'b0;
      lock_lost_o  <= 1'b0;
    end else begin
      data_s1_reg <= tdata_64b_i;
      locked_o    <= (state_reg == SYNC);
      lock_lost_o <= 1'b0;
      tvalid_o    <= 1'b0;
      case (state_reg)
        HUNT: begin
          pos_reg      <= '0;
          good_cnt_reg <= '0;
          miss_cnt_reg <= '0;
          if (aligned_i && faw_s1) begin
            pos_reg      <= POS_W'(1);
            good_cnt_reg <= 4'd1;
            state_reg    <= PRESYNC;
          end
        end
        PRESYNC: begin
          if (!aligned_i || (slot_s1 && !faw_s1)) begin
            state_reg    <= HUNT;
            pos_reg      <= '0;
            good_cnt_reg <= '0;
          end else begin
            pos_reg <= pos_inc;
            if (slot_s1) begin
              good_cnt_reg <= good_cnt_reg + 4'd1;
              if ((good_cnt_reg + 4'd1) == LOCK_N) begin
                state_reg    <= SYNC;
                miss_cnt_reg <= '0;
              end
            end
          end
        end
        SYNC: begin
          // The FAW slot is always dropped; any other slot is payload, even if it looks like a FAW.
          if (aligned_i && !slot_s1) begin
            tvalid_o <= 1'b1;
            tdata_o  <= data_s1_reg;
          end
          if (!aligned_i || unlock_s1) begin
            state_reg    <= HUNT;
            pos_reg      <= '0;
            good_cnt_reg <= '0;
            miss_cnt_reg <= '0;
            lock_lost_o  <= 1'b1;
          end else begin
            pos_reg <= pos_inc;
            if (slot_s1) miss_cnt_reg <= miss_s1 ? miss_cnt_reg + 4'd1 : 4'd0;
          end
        end
        default: begin
          state_reg    <= HUNT;
          pos_reg      <= '0;
          good_cnt_reg <= '0;
          miss_cnt_reg <= '0;
        end
      endcase
    end
  end

`ifdef QECIPHY_RX_FAW_MON_STATS_EN
  // Misses are counted even when the same slot also sees aligned_i drop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      faw_err_cnt_o <= '0;
    end else if (miss_s1 && (faw_err_cnt_o != 16'hFFFF)) begin
      faw_err_cnt_o <= faw_err_cnt_o + 16'd1;
    end
  end
`else
  assign faw_err_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_qeciphy_rx_faw_monitor.sv
// Self-checking bench for qeciphy_rx_faw_monitor: directed framing scenarios plus randomized frames vs a slot-level model.
module tb_qeciphy_rx_faw_monitor;
  localparam int P       = 8;
  localparam int LOCKN   = 4;
  localparam int UNLOCKN = 3;
  localparam logic [63:0] FAW = 64'hA5C3_96F0_0F69_3C5A;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [63:0] tdata_64b_i;
  logic        aligned_i;
  logic [63:0] tdata_o;
  logic        tvalid_o;
  logic        locked_o;
  logic        lock_lost_o;
  logic [15:0] faw_err_cnt_o;

  always #5 clk_i = ~clk_i;

  qeciphy_rx_faw_monitor #(
    .FAW_PERIOD  (P),
    .LOCK_COUNT  (LOCKN),
    .UNLOCK_COUNT(UNLOCKN)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .tdata_64b_i  (tdata_64b_i),
    .aligned_i    (aligned_i),
    .tdata_o      (tdata_o),
    .tvalid_o     (tvalid_o),
    .locked_o     (locked_o),
    .lock_lost_o  (lock_lost_o),
    .faw_err_cnt_o(faw_err_cnt_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lost_seen = 0;

  // Reference model: mode 0=searching, 1=confirming, 2=locked; slot = position inside the frame.
  int          m_mode, m_slot, m_good, m_miss, m_errs;
  logic [63:0] m_prev;
  logic [63:0] e_tdata;
  logic        e_tvalid, e_locked, e_lost;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_slot = 0; m_good = 0; m_miss = 0; m_errs = 0;
    m_prev = '0; e_tdata = '0; e_tvalid = 1'b0; e_locked = 1'b0; e_lost = 1'b0;
  endtask

  task automatic model_step(input logic [63:0] w, input logic al);
    bit isf;
    isf = (w == FAW);
    e_locked = (m_mode == 2);
    e_lost = 1'b0;
    e_tvalid = 1'b0;
    if (m_mode == 2) begin
      if (al && m_slot != 0) begin
        e_tvalid = 1'b1;
        e_tdata = w;
      end
      if (m_slot == 0) begin
        if (isf) m_miss = 0;
        else begin
          m_miss++;
          if (m_errs < 65535) m_errs++;
        end
      end
      if (!al || m_miss == UNLOCKN) begin
        m_mode = 0; m_slot = 0; m_miss = 0; m_good = 0; e_lost = 1'b1;
      end else m_slot = (m_slot + 1) % P;
    end else if (m_mode == 1) begin
      if (!al || (m_slot == 0 && !isf)) begin
        m_mode = 0; m_slot = 0; m_good = 0;
      end else begin
        if (m_slot == 0) begin
          m_good++;
          if (m_good == LOCKN) begin m_mode = 2; m_miss = 0; end
        end
        m_slot = (m_slot + 1) % P;
      end
    end else if (al && isf) begin
      m_mode = 1; m_slot = 1; m_good = 1;
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef QECIPHY_RX_FAW_MON_STATS_EN
    return 16'(m_errs);
`else
    return 16'd0;
`endif
  endfunction

  task automatic send(input logic [63:0] w, input logic al);
    tdata_64b_i = w;
    aligned_i   = al;
    model_step(m_prev, al);
    m_prev = w;
    @(posedge clk_i);
    #1;
    if (lock_lost_o === 1'b1) lost_seen++;
    check("tvalid", 64'(tvalid_o), 64'(e_tvalid));
    check("tdata", tdata_o, e_tdata);
    check("locked", 64'(locked_o), 64'(e_locked));
    check("lock_lost", 64'(lock_lost_o), 64'(e_lost));
    check("faw_err_cnt", 64'(faw_err_cnt_o), 64'(exp_cnt()));
  endtask

  task automatic send_frame(input logic [63:0] slot0, input int stray, input bit rnd);
    logic [63:0] w;
    send(slot0, 1'b1);
    for (int p = 1; p < P; p++) begin
      w = rnd ? {$urandom(), $urandom()} : 64'(p);
      if (p == stray) w = FAW;
      send(w, 1'b1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tvalid"}, 64'(tvalid_o), 64'd0);
    check({tag, "_tdata"}, tdata_o, 64'd0);
    check({tag, "_locked"}, 64'(locked_o), 64'd0);
    check({tag, "_lost"}, 64'(lock_lost_o), 64'd0);
    check({tag, "_cnt"}, 64'(faw_err_cnt_o), 64'd0);
  endtask

  initial begin
    int lost0, err0;
    logic [63:0] w, slot0;
    logic al;

    rst_n_i = 1'b0;
    tdata_64b_i = '0;
    aligned_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    #2 rst_n_i = 1'b1;

    // Lock with payload 1..7
    for (int f = 0; f < 6; f++) send_frame(FAW, 0, 1'b0);
    check("locked_after_lock", 64'(locked_o), 64'd1);
    $display("lock phase done: locked=%0d", locked_o);

    // Stray FAW at pos 3 is forwarded as payload
    send_frame(FAW, 3, 1'b1);
    send_frame(FAW, 0, 1'b1);
    check("locked_after_stray", 64'(locked_o), 64'd1);

    // Loss of lock: three corrupt FAW slots
    lost0 = lost_seen;
    err0 = m_errs;
    for (int f = 0; f < 3; f++) send_frame(64'hBAD0 + 64'(f), 0, 1'b1);
    send(64'h1234, 1'b1);
    check("lost_pulses_miss", 64'(lost_seen - lost0), 64'd1);
    check("locked_after_loss", 64'(locked_o), 64'd0);
`ifdef QECIPHY_RX_FAW_MON_STATS_EN
    check("err_cnt_loss", 64'(faw_err_cnt_o), 64'(err0 + 3));
`else
    check("err_cnt_loss", 64'(faw_err_cnt_o), 64'd0);
`endif
    $display("loss phase done: err_cnt=%0d", faw_err_cnt_o);

    // PRESYNC abort: 2 good FAWs then 0xDEAD, then 4 good frames to relock
    for (int p = 1; p < P; p++) send(64'(p), 1'b1);
    send_frame(FAW, 0, 1'b0);
    send_frame(FAW, 0, 1'b0);
    send_frame(64'hDEAD, 0, 1'b0);
    check("locked_after_abort", 64'(locked_o), 64'd0);
    for (int f = 0; f < 3; f++) send_frame(FAW, 0, 1'b0);
    check("locked_after_3_more", 64'(locked_o), 64'd0);
    send_frame(FAW, 0, 1'b0);
    check("locked_after_4_more", 64'(locked_o), 64'd1);
    $display("abort phase done: locked=%0d", locked_o);

    // Miss recovery: bad, bad, good, bad, bad, good
    lost0 = lost_seen;
    err0 = m_errs;
    send_frame(64'hB1, 0, 1'b1);
    send_frame(64'hB2, 0, 1'b1);
    send_frame(FAW, 0, 1'b1);
    send_frame(64'hB3, 0, 1'b1);
    send_frame(64'hB4, 0, 1'b1);
    send_frame(FAW, 0, 1'b1);
    check("lost_pulses_recovery", 64'(lost_seen - lost0), 64'd0);
    check("locked_after_recovery", 64'(locked_o), 64'd1);
`ifdef QECIPHY_RX_FAW_MON_STATS_EN
    check("err_cnt_recovery", 64'(faw_err_cnt_o), 64'(err0 + 4));
`endif
    $display("recovery phase done: err_cnt=%0d", faw_err_cnt_o);

    // Randomized frames: occasional missing FAWs, stray FAWs and alignment drops
    for (int f = 0; f < 40; f++) begin
      slot0 = ($urandom_range(9) < 8) ? FAW : {$urandom(), $urandom()};
      for (int p = 0; p < P; p++) begin
        w = (p == 0) ? slot0 : (($urandom_range(15) == 0) ? FAW : {$urandom(), $urandom()});
        al = ($urandom_range(49) != 0);
        send(w, al);
      end
    end
    $display("random phase done: checks=%0d", n_checks);

    // aligned_i drop while locked, then reset mid-frame
    for (int f = 0; f < 10; f++) send_frame(FAW, 0, 1'b1);
    check("locked_before_drop", 64'(locked_o), 64'd1);
    lost0 = lost_seen;
    send(FAW, 1'b1);
    send(64'h11, 1'b1);
    send(64'h22, 1'b1);
    send(64'h33, 1'b0);
    send(64'h44, 1'b1);
    check("lost_pulses_drop", 64'(lost_seen - lost0), 64'd1);
    for (int p = 5; p < P; p++) send(64'(p), 1'b1);
    send(FAW, 1'b1);
    send(64'h55, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("midreset_hold");
    #2 rst_n_i = 1'b1;
    for (int f = 0; f < 6; f++) send_frame(FAW, 0, 1'b1);
    check("locked_after_reset", 64'(locked_o), 64'd1);
    $display("reset phase done: locked=%0d", locked_o);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
